// File: rtl/rat_uart_tx_port.sv
// rat_uart_tx_port: RAT MCU port-mapped UART transmitter.
// OUT to DATA_PORT_ID queues a byte in a small FIFO; bytes are sent 8N1 on TX.
// OUT to STATUS_PORT_ID is a control write (bit0 clears overflow, bit1 flushes).
// STATUS_RD = {count[3:0], overflow, full, empty, busy}.
// Optional: define RAT_UART_PARITY_EN to append an even-parity bit (8E1 frame).
// Handshake: an I/O write is accepted exactly once per IO_STRB rising edge
// (IO_STRB high while its registered copy is low); strobe length is irrelevant.
module rat_uart_tx_port #(
    parameter logic [7:0] DATA_PORT_ID   = 8'hB0,
    parameter logic [7:0] STATUS_PORT_ID = 8'hB1,
    parameter int         CLK_DIV        = 434,
    parameter int         FIFO_DEPTH     = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] STATUS_RD,
    output logic       TX,
    output logic       TX_DONE
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam int              BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]      DEPTH_CNT = 4'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RAT_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q;
    logic              strb_q;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [3:0]        count_q;
    logic              ovf_q;

    logic wr_evt, data_wr, ctrl_wr, flush, ovf_clr;
    logic fifo_empty, fifo_full, push, drop, pop;

    assign wr_evt     = IO_STRB & ~strb_q;
    assign data_wr    = wr_evt && (PORT_ID == DATA_PORT_ID);
    assign ctrl_wr    = wr_evt && (PORT_ID == STATUS_PORT_ID);
    assign flush      = ctrl_wr & OUT_PORT[1];
    assign ovf_clr    = ctrl_wr & OUT_PORT[0];
    assign fifo_empty = (count_q == 4'd0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
    assign push       = data_wr && (!fifo_full || pop);
    assign drop       = data_wr && fifo_full && !pop;

    assign STATUS_RD  = {count_q, ovf_q, fifo_full, fifo_empty, state_q != ST_IDLE};

    // Strobe edge detector register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) strb_q <= 1'b0;
        else          strb_q <= IO_STRB;
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= OUT_PORT;
    end

    // FIFO pointers, occupancy and sticky overflow; flush wins over a same-cycle pop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (flush) begin
                rd_ptr  <= wr_ptr;
                count_q <= 4'd0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + 4'd1;
                    2'b01:   count_q <= count_q - 4'd1;
                    default: count_q <= count_q;
                endcase
            end
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Transmitter state, baud counter, bit index and the byte being sent.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            if (pop) shift_q <= mem[rd_ptr];
        end
    end

    // Next-state, serial output and done pulse; each non-idle state lasts CLK_DIV cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        TX      = 1'b1;
        TX_DONE = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop     = 1'b1;
                    baud_d  = BAUD_LAST;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                TX = 1'b0;
                if (baud_q == '0) begin
                    baud_d  = BAUD_LAST;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                TX = shift_q[bit_q];
                if (baud_q == '0) begin
                    baud_d = BAUD_LAST;
                    if (bit_q == 3'd7) begin
`ifdef RAT_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`ifdef RAT_UART_PARITY_EN
            ST_PARITY: begin
                TX = ^shift_q;
                if (baud_q == '0) begin
                    baud_d  = BAUD_LAST;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_q == '0) begin
                    TX_DONE = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// tb_rat_uart_tx_port: randomized and directed bench for rat_uart_tx_port.
// A timeline reference model (byte queue + frame cycle countdown) predicts
// TX, TX_DONE and STATUS_RD every cycle; directed scenarios add fixed checks.
module tb_rat_uart_tx_port;

    localparam int         CLK_DIV    = 4;
    localparam int         DEPTH      = 8;
    localparam logic [7:0] DATA_ID    = 8'hB0;
    localparam logic [7:0] STAT_ID    = 8'hB1;
`ifdef RAT_UART_PARITY_EN
    localparam int         FRAME_BITS = 11;
`else
    localparam int         FRAME_BITS = 10;
`endif
    localparam int         FRAME      = FRAME_BITS * CLK_DIV;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] STATUS_RD;
    logic       TX;
    logic       TX_DONE;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    rat_uart_tx_port #(
        .DATA_PORT_ID  (DATA_ID),
        .STATUS_PORT_ID(STAT_ID),
        .CLK_DIV       (CLK_DIV),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .STATUS_RD(STATUS_RD),
        .TX       (TX),
        .TX_DONE  (TX_DONE)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] m_cur  = 8'h00;
    int         m_left = 0;       // cycles of the current frame still to go, 0 = idle
    logic       m_ovf  = 1'b0;
    logic       m_strb = 1'b0;
    logic       m_evt, m_flush, m_pop;
    int         m_sz;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            exp_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
            m_strb = 1'b0;
        end else begin
            m_evt   = IO_STRB && !m_strb;
            m_strb  = IO_STRB;
            m_flush = m_evt && (PORT_ID == STAT_ID) && OUT_PORT[1];
            m_sz    = exp_q.size();
            m_pop   = (m_left == 0) && (m_sz > 0) && !m_flush;
            if (m_left > 0) m_left--;
            if (m_pop) begin
                m_cur  = exp_q.pop_front();
                m_left = FRAME;
            end
            if (m_evt && PORT_ID == DATA_ID) begin
                if (m_sz < DEPTH || m_pop) exp_q.push_back(OUT_PORT);
                else                       m_ovf = 1'b1;
            end
            if (m_evt && PORT_ID == STAT_ID) begin
                if (OUT_PORT[0]) m_ovf = 1'b0;
                if (OUT_PORT[1]) exp_q.delete();
            end
        end
    end

    function automatic logic model_tx();
        int slot;
        if (m_left == 0) return 1'b1;
        slot = (FRAME - m_left) / CLK_DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
`ifdef RAT_UART_PARITY_EN
        if (slot == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] model_status();
        int c;
        c = exp_q.size();
        return {4'(c), m_ovf, c == DEPTH, c == 0, m_left != 0};
    endfunction

    // scoreboard: every cycle, compare against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check_eq("tx", {7'b0, TX}, {7'b0, model_tx()});
            check_eq("tx_done", {7'b0, TX_DONE}, {7'b0, (m_left == 1)});
            check_eq("status", STATUS_RD, model_status());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic io_write(input logic [7:0] pid, input logic [7:0] d, input int hi, input int lo);
        @(negedge CLK);
        PORT_ID  = pid;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        repeat (hi) @(negedge CLK);
        IO_STRB = 1'b0;
        repeat (lo) @(negedge CLK);
    endtask

    task automatic wait_tx_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!TX_DONE && n < limit);
        if (!TX_DONE) check_eq("tx_done_timeout", 8'h00, 8'h01);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (STATUS_RD !== 8'h02 && n < limit);
        if (STATUS_RD !== 8'h02) check_eq("idle_timeout", STATUS_RD, 8'h02);
    endtask

    // ---------------- stimulus ----------------
    int         pulses;
    int         k_tab[2] = '{3, 8};
    logic [7:0] d;
    int         r;

    initial begin
        #1 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check_eq("rst_status", STATUS_RD, 8'h02);
        check_eq("rst_tx", {7'b0, TX}, 8'h01);
        check_eq("rst_tx_done", {7'b0, TX_DONE}, 8'h00);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // single byte with a 2-cycle strobe
        io_write(DATA_ID, 8'hA5, 2, 0);
        check_eq("start_latency", {7'b0, TX}, 8'h00);
        pulses = 0;
        repeat (FRAME + 8) begin
            @(negedge CLK);
            if (TX_DONE) pulses++;
        end
        check_eq("done_pulses", 8'(pulses), 8'd1);
        check_eq("a5_status", STATUS_RD, 8'h02);

`ifdef RAT_UART_PARITY_EN
        // parity bit for 8'h07 (odd weight) and 8'h03 (even weight)
        io_write(DATA_ID, 8'h07, 1, 0);
        repeat (1 + 9 * CLK_DIV) @(negedge CLK);
        check_eq("parity_07", {7'b0, TX}, 8'h01);
        wait_idle(2 * FRAME);
        io_write(DATA_ID, 8'h03, 1, 0);
        repeat (1 + 9 * CLK_DIV) @(negedge CLK);
        check_eq("parity_03", {7'b0, TX}, 8'h00);
        wait_idle(2 * FRAME);
`endif

        // fill past full while a frame is in flight
        io_write(DATA_ID, 8'h11, 1, 1);
        for (int i = 0; i < 10; i++) io_write(DATA_ID, 8'(8'h20 + i), 1, 1);
        check_eq("fill_status", STATUS_RD, 8'h8D);
        io_write(STAT_ID, 8'h01, 1, 1);
        check_eq("ovf_clear", STATUS_RD, 8'h85);
        wait_idle(12 * FRAME);
        check_eq("drain_status", STATUS_RD, 8'h02);

        // write event in the same cycle as the IDLE pop
        foreach (k_tab[j]) begin
            io_write(DATA_ID, 8'h5A, 1, 1);
            for (int i = 0; i < k_tab[j]; i++) io_write(DATA_ID, 8'($urandom_range(0, 255)), 1, 1);
            wait_tx_done(2 * FRAME);
            io_write(DATA_ID, 8'hC3, 1, 0);
            check_eq("pushpop_count", {4'h0, STATUS_RD[7:4]}, 8'(k_tab[j]));
            check_eq("pushpop_ovf", {7'b0, STATUS_RD[3]}, 8'h00);
            wait_idle(12 * FRAME);
        end

        // flush during DATA of the first byte
        io_write(DATA_ID, 8'h81, 1, 1);
        io_write(DATA_ID, 8'h82, 1, 1);
        io_write(DATA_ID, 8'h83, 1, 1);
        repeat (8) @(negedge CLK);
        io_write(STAT_ID, 8'h02, 1, 1);
        check_eq("flush_busy", STATUS_RD, 8'h03);
        wait_tx_done(2 * FRAME);
        @(negedge CLK);
        check_eq("flush_after", STATUS_RD, 8'h02);
        repeat (2 * FRAME) @(negedge CLK);
        check_eq("flush_quiet", STATUS_RD, 8'h02);

        // asynchronous reset during data bit 4
        io_write(DATA_ID, 8'hF0, 1, 1);
        io_write(DATA_ID, 8'h0F, 1, 1);
        repeat (18) @(negedge CLK);
        check_eq("pre_reset_busy", {7'b0, STATUS_RD[0]}, 8'h01);
        #2 RESET_N = 1'b0;
        #1;
        check_eq("async_tx", {7'b0, TX}, 8'h01);
        check_eq("async_status", STATUS_RD, 8'h02);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2 * FRAME) @(negedge CLK);
        check_eq("post_reset", STATUS_RD, 8'h02);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 5);
            d = 8'($urandom_range(0, 255));
            if (r <= 2) begin
                io_write(DATA_ID, d, $urandom_range(1, 3), $urandom_range(1, 6));
            end else if (r == 3) begin
                if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
                io_write(STAT_ID, d, $urandom_range(1, 3), $urandom_range(1, 6));
            end else begin
                io_write(8'($urandom_range(0, 255)), d, $urandom_range(1, 3), $urandom_range(1, 6));
            end
            if ($urandom_range(0, 19) == 0) repeat ($urandom_range(40, 150)) @(negedge CLK);
        end
        io_write(STAT_ID, 8'h01, 1, 1);
        wait_idle(12 * FRAME);
        check_eq("final_status", STATUS_RD, 8'h02);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rat_uart_tx_port.md
Name: rat_uart_tx_port

Overview:
- Port-mapped UART transmitter that sits on the RAT MCU I/O bus. The MCU initiates with OUT/IN instructions; this block responds.
- MCU writes bytes to a data port. The block queues them in a small FIFO and serializes each one as 8N1 on a TX pin.
- Status is presented on a read bus, which the wrapper input mux selects when PORT_ID matches STATUS_PORT_ID.
- Raises a one-cycle TX_DONE pulse per completed frame, for use as an MCU interrupt source.

Parameters:
- DATA_PORT_ID, 8'hB0: OUT to this ID pushes OUT_PORT into the FIFO.
- STATUS_PORT_ID, 8'hB1: OUT to this ID is a control write; IN from this ID reads status.
- CLK_DIV, 434: CLK cycles per bit (100 MHz / 230400, or 50 MHz / 115200); must be ≥ 2.
- FIFO_DEPTH, 8: FIFO entries; power of two, 2..8.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous reset, active-low
- PORT_ID  in  8  MCU port id
- OUT_PORT  in  8  MCU output data
- IO_STRB  in  1  MCU I/O strobe; may stay high for more than one CLK cycle
- STATUS_RD  out  8  status byte, combinational from registers
- TX  out  1  serial output, idle high
- TX_DONE  out  1  one-cycle pulse at end of each stop bit

Behaviour:
- Reset (RESET_N low, asynchronous) forces:
  - TX = 1, TX_DONE = 0
  - FIFO empty, count 0, overflow flag 0
  - FSM in IDLE, baud counter 0
  - Takes effect immediately, including mid-frame; the partial frame is abandoned.
- Strobe qualification: IO_STRB is registered once. A write event is the cycle where IO_STRB = 1 and the registered copy = 0. Exactly one event per strobe, whatever its length.
- Data write (event and PORT_ID == DATA_PORT_ID):
  - Push OUT_PORT if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise drop the byte and set overflow = 1 (sticky).
- Control write (event and PORT_ID == STATUS_PORT_ID):
  - OUT_PORT[0] = 1 clears overflow.
  - OUT_PORT[1] = 1 flushes the FIFO (count to 0). A frame already in progress completes normally.
  - Flush has priority over a same-cycle pop.
- STATUS_RD layout:
  - [0] busy (FSM not IDLE)
  - [1] empty
  - [2] full
  - [3] overflow
  - [7:4] count (0..FIFO_DEPTH)
- Simultaneous push and pop: both occur; count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE → START → DATA → STOP → IDLE:
  - IDLE: TX = 1. If FIFO not empty, pop into shift register, load baud counter, go to START.
  - START: TX = 0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each held for CLK_DIV cycles. A 3-bit bit index counts 0..7.
  - STOP: TX = 1 for CLK_DIV cycles. On the last cycle, TX_DONE = 1 and go to IDLE.
- Latency:
  - Write event in cycle N to an empty FIFO with FSM IDLE gives: push at edge N, pop at N+1, TX low from cycle N+2.
  - Back-to-back frames carry exactly 1 IDLE cycle between the end of STOP and the next START, so the effective stop is CLK_DIV+1 cycles.
- Frame length: exactly 10·CLK_DIV cycles from first START cycle to last STOP cycle.

Optional Feature:
- Macro RAT_UART_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP.
  - TX carries the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame becomes 11·CLK_DIV cycles.
  - STATUS_RD[3:0] is unchanged.
- When undefined: no PARITY state, 8N1 only, no parity logic synthesized.

Test Plan:
- Reset and write: CLK_DIV=4; write 8'hA5 to DATA_PORT_ID with a 2-cycle IO_STRB → exactly one push, TX low 2 cycles after the strobe edge, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, TX_DONE pulse on the 40th frame cycle, STATUS_RD = 8'h02 afterwards.
- FIFO fill and overflow: depth 8, FSM stalled mid-frame; write 10 bytes → STATUS_RD count = 8, full = 1, overflow = 1. Control write 8'h01 → overflow = 0. All 8 queued bytes plus the in-flight byte transmit in order.
- Simultaneous push and pop: count = 3; data write in the same cycle IDLE pops → count stays 3, no overflow.
- Flush mid-frame: 3 bytes queued, control write 8'h02 during DATA of byte 1 → byte 1 completes, no further frames, STATUS_RD = 8'h02 after STOP.
- Async reset mid-frame: assert RESET_N low during bit 4 → TX = 1 and STATUS_RD = 8'h02 immediately, without waiting for a CLK edge. Release → no residual frame.
- Parity (RAT_UART_PARITY_EN): send 8'h07 → parity bit 1, frame 44 cycles at CLK_DIV=4. Send 8'h03 → parity bit 0.
